// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: (x, y) -> magnitude, quadrant and in-quadrant angle.
// One micro-rotation per clock on a shared datapath with valid/ready on both sides.
module cordic_vectoring_iter #(
  parameter int                      N    = 16,
  parameter int                      DW   = 16,
  parameter int                      AW   = 16,
  parameter logic [N-1:0][AW-1:0]    ATAN = '0,
  parameter int                      KW   = 16,
  parameter logic [KW-1:0]           K    = KW'(39797),
  parameter int                      OW   = DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] y_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [OW-1:0] mag_o,
  output logic [AW-1:0] angle_o,
  output logic [1:0]    quadrant_o
);

  // Fractional guard bits keep shift truncation far below one angle LSB.
  localparam int GB = 6;
  localparam int XW = DW + 3 + GB;
  localparam int ZW = AW + 2;
  localparam int PW = XW + KW + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] HALF = PW'(1) << (KW + GB - 1);

  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

  state_t               state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic [CW-1:0]        i_q, i_d;
  logic [1:0]           quad_q, quad_d;
  logic [OW-1:0]        mag_q, mag_d;
  logic [AW-1:0]        angle_q, angle_d;
  logic [1:0]           quad_out_q, quad_out_d;

  logic signed [XW-1:0] xin, yin, xsh, ysh;
  logic signed [ZW-1:0] atan_i;
  logic signed [PW-1:0] prod, prod_r, mag_full;
  logic [OW-1:0]        mag_sat;
  logic [AW-1:0]        ang_sat;
  logic                 x_pos, x_neg, y_pos, y_neg, y_gt0;

  always_comb begin
    xin      = {{3{x_i[DW-1]}}, x_i, {GB{1'b0}}};
    yin      = {{3{y_i[DW-1]}}, y_i, {GB{1'b0}}};
    x_pos    = !x_i[DW-1] && (x_i != '0);
    x_neg    = x_i[DW-1];
    y_pos    = !y_i[DW-1] && (y_i != '0);
    y_neg    = y_i[DW-1];
    y_gt0    = !y_q[XW-1] && (y_q != '0);
    xsh      = x_q >>> i_q;
    ysh      = y_q >>> i_q;
    atan_i   = $signed({2'b00, ATAN[i_q]});
    prod     = $signed({{(PW-XW){x_q[XW-1]}}, x_q}) * $signed({{(PW-KW){1'b0}}, K});
    prod_r   = prod + $signed(HALF);
    mag_full = prod_r >>> (KW + GB);

    if (mag_full[PW-1])            mag_sat = '0;
    else if (|mag_full[PW-2:OW])   mag_sat = '1;
    else                           mag_sat = mag_full[OW-1:0];

    if (z_q[ZW-1])                 ang_sat = '0;
    else if (|z_q[ZW-2:AW])        ang_sat = '1;
    else                           ang_sat = z_q[AW-1:0];
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    i_d        = i_q;
    quad_d     = quad_q;
    mag_d      = mag_q;
    angle_d    = angle_q;
    quad_out_d = quad_out_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          z_d     = '0;
          i_d     = '0;
          state_d = ITER;
          // Fold the vector into the first quadrant; (0,0) takes the last branch.
          if (x_pos && !y_neg) begin
            x_d = xin;  y_d = yin;  quad_d = 2'd0;
          end else if (!x_pos && y_pos) begin
            x_d = yin;  y_d = -xin; quad_d = 2'd1;
          end else if (x_neg && !y_pos) begin
            x_d = -xin; y_d = -yin; quad_d = 2'd2;
          end else if (!x_neg && y_neg) begin
            x_d = -yin; y_d = xin;  quad_d = 2'd3;
          end else begin
            x_d = xin;  y_d = yin;  quad_d = 2'd0;
          end
        end
      end
      ITER: begin
        if (y_gt0) begin
          x_d = x_q + ysh;
          y_d = y_q - xsh;
          z_d = z_q + atan_i;
        end else begin
          x_d = x_q - ysh;
          y_d = y_q + xsh;
          z_d = z_q - atan_i;
        end
        if (i_q == CW'(N - 1)) state_d = SCALE;
        else                   i_d     = i_q + CW'(1);
      end
      SCALE: begin
        mag_d      = mag_sat;
        angle_d    = ang_sat;
        quad_out_d = quad_q;
        state_d    = DONE;
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      i_q        <= '0;
      quad_q     <= '0;
      mag_q      <= '0;
      angle_q    <= '0;
      quad_out_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      i_q        <= i_d;
      quad_q     <= quad_d;
      mag_q      <= mag_d;
      angle_q    <= angle_d;
      quad_out_q <= quad_out_d;
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign valid_o    = (state_q == DONE);
  assign mag_o      = mag_q;
  assign angle_o    = angle_q;
  assign quadrant_o = quad_out_q;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Bench for cordic_vectoring_iter: floating-point reference model, per-cycle compare
// process, directed literal cases, backpressure, mid-job reset and a random sweep.
module tb_cordic_vectoring_iter;
  localparam int  N  = 16;
  localparam int  DW = 16;
  localparam int  AW = 16;
  localparam int  OW = 16;
  localparam real PI = 3.14159265358979323846;
  localparam logic [N-1:0][AW-1:0] ATAN_T = {
    16'd1, 16'd3, 16'd5, 16'd10, 16'd20, 16'd41, 16'd81, 16'd163,
    16'd326, 16'd652, 16'd1303, 16'd2604, 16'd5188, 16'd10221, 16'd19344, 16'd32768};

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [DW-1:0] x_i = '0;
  logic [DW-1:0] y_i = '0;
  logic          ready_o, valid_o;
  logic [OW-1:0] mag_o;
  logic [AW-1:0] angle_o;
  logic [1:0]    quadrant_o;

  cordic_vectoring_iter #(.N(N), .DW(DW), .AW(AW), .ATAN(ATAN_T), .OW(OW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .x_i(x_i), .y_i(y_i), .valid_o(valid_o), .ready_i(ready_i),
    .mag_o(mag_o), .angle_o(angle_o), .quadrant_o(quadrant_o));

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // Ideal result: quadrant by the folding rules, angle and magnitude in real arithmetic.
  function automatic void model(input int x, input int y, output int q, output real ang, output real mag);
    int xp, yp;
    if (x > 0 && y >= 0)      begin q = 0; xp = x;  yp = y;  end
    else if (x <= 0 && y > 0) begin q = 1; xp = y;  yp = -x; end
    else if (x < 0 && y <= 0) begin q = 2; xp = -x; yp = -y; end
    else if (x >= 0 && y < 0) begin q = 3; xp = -y; yp = x;  end
    else                      begin q = 0; xp = 0;  yp = 0;  end
    mag = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    ang = (xp == 0 && yp == 0) ? 0.0 : $atan2(real'(yp), real'(xp)) / (PI / 2.0) * 65536.0;
    if (ang > 65535.0) ang = 65535.0;
    if (mag > 65535.0) mag = 65535.0;
  endfunction

  typedef struct {int x; int y;} vec_t;
  vec_t q_exp[$];
  int   cyc = 0;
  int   acc = 0;
  bit   busy = 1'b0;
  bit   rst_seen = 1'b0;
  bit   started = 1'b0;

  // Job-level model: one job in flight, result due N+1 edges after acceptance.
  always @(posedge clk_i) begin
    vec_t v;
    if (rst_i) begin
      q_exp.delete();
      busy     <= 1'b0;
      rst_seen <= 1'b1;
      started  <= 1'b1;
    end else begin
      rst_seen <= 1'b0;
      if (busy) begin
        if ((cyc - acc >= N + 1) && ready_i) begin
          busy <= 1'b0;
          void'(q_exp.pop_front());
        end
      end else if (valid_i) begin
        busy <= 1'b1;
        acc  <= cyc + 1;
        v.x = int'($signed(x_i));
        v.y = int'($signed(y_i));
        q_exp.push_back(v);
      end
    end
    cyc <= cyc + 1;
  end

  int h_mag, h_ang, h_q;
  bit prev_v = 1'b0;

  always @(negedge clk_i) begin
    bit  ev;
    int  q;
    real a, m;
    if (started) begin
      ev = busy && (cyc - acc >= N + 1);
      if (rst_seen) begin
        chk(valid_o == 1'b0, "rst_valid_o", valid_o, 0);
        chk(mag_o == '0, "rst_mag_o", mag_o, 0);
        chk(angle_o == '0, "rst_angle_o", angle_o, 0);
        chk(quadrant_o == 2'd0, "rst_quadrant_o", quadrant_o, 0);
      end
      chk(ready_o == !busy, "ready_o", ready_o, !busy);
      chk(valid_o == ev, "valid_o", valid_o, ev);
      if (ev && valid_o) begin
        if (q_exp.size() == 0) begin
          chk(1'b0, "result_without_job", 1, 0);
        end else begin
          model(q_exp[0].x, q_exp[0].y, q, a, m);
          chk(int'(quadrant_o) == q, "quadrant", quadrant_o, q);
          chk(rabs(real'(angle_o) - a) <= 4.0, "angle", angle_o, $rtoi(a + 0.5));
          chk(rabs(real'(mag_o) - m) <= 3.0 + 1.0e-4 * m, "mag", mag_o, $rtoi(m + 0.5));
          if (prev_v) begin
            chk(int'(mag_o) == h_mag, "hold_mag", mag_o, h_mag);
            chk(int'(angle_o) == h_ang, "hold_angle", angle_o, h_ang);
            chk(int'(quadrant_o) == h_q, "hold_quadrant", quadrant_o, h_q);
          end
          h_mag = int'(mag_o);
          h_ang = int'(angle_o);
          h_q   = int'(quadrant_o);
        end
      end
      prev_v = ev && valid_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input int x, input int y);
    x_i = DW'(x);
    y_i = DW'(y);
    valid_i = 1'b1;
    for (int k = 0; k < 200 && !ready_o; k++) tick();
    if (!ready_o) chk(1'b0, "accept_timeout", 0, 1);
    tick();
    valid_i = 1'b0;
  endtask

  // Optionally drives junk on the input side while busy; it must be ignored.
  task automatic wait_result(input bit noise);
    int k;
    k = 0;
    while (!valid_o && k < 100) begin
      if (noise) begin
        valid_i = 1'($urandom);
        x_i = DW'($urandom);
        y_i = DW'($urandom);
      end
      tick();
      k++;
    end
    valid_i = 1'b0;
    if (!valid_o) chk(1'b0, "result_timeout", 0, 1);
  endtask

  task automatic take(input int hold);
    for (int k = 0; k < hold; k++) tick();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  task automatic lit(input string name, input int lq, input int la, input int lta,
                     input int lm, input int ltm);
    int da, dm;
    da = int'(angle_o) - la;
    dm = int'(mag_o) - lm;
    chk(int'(quadrant_o) == lq, {name, "_quadrant"}, quadrant_o, lq);
    chk((da <= lta) && (da >= -lta), {name, "_angle"}, angle_o, la);
    chk((dm <= ltm) && (dm >= -ltm), {name, "_mag"}, mag_o, lm);
  endtask

  task automatic directed(input int x, input int y, input string name, input int lq,
                          input int la, input int lta, input int lm, input int ltm);
    send(x, y);
    wait_result(1'b0);
    lit(name, lq, la, lta, lm, ltm);
    take(0);
  endtask

  initial begin
    int x, y, hm, ha, hq;
    int t_acc, lat;

    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    // Latency measured from the accept edge to the first cycle with valid_o.
    send(16384, 0);
    t_acc = cyc;
    lat = 0;
    while (!valid_o && lat < 100) begin tick(); lat++; end
    chk(cyc - t_acc == N + 1, "latency_edges", cyc - t_acc, N + 1);
    lit("d_x_axis", 0, 0, 4, 16384, 3);
    take(0);

    directed(0, 16384, "d_y_axis", 1, 0, 4, 16384, 3);
    directed(-16384, -16384, "d_q2", 2, 32768, 4, 23170, 3);
    directed(0, 0, "d_zero", 0, 0, 0, 0, 0);
    directed(-32768, -32768, "d_extreme", 2, 32768, 4, 46341, 4);
    directed(32767, -1, "d_q3_clamp", 3, 65535, 4, 32767, 3);

    // Backpressure with a new vector waiting on the input.
    send(12000, -7000);
    wait_result(1'b0);
    hm = int'(mag_o); ha = int'(angle_o); hq = int'(quadrant_o);
    x_i = DW'(5000);
    y_i = DW'(5000);
    valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk(ready_o == 1'b0, "bp_ready_o", ready_o, 0);
      chk(valid_o == 1'b1, "bp_valid_o", valid_o, 1);
      chk(int'(mag_o) == hm && int'(angle_o) == ha && int'(quadrant_o) == hq,
          "bp_stable", mag_o, hm);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk(valid_o == 1'b0, "bp_release_valid", valid_o, 0);
    chk(ready_o == 1'b1, "bp_release_ready", ready_o, 1);
    tick();
    valid_i = 1'b0;
    chk(ready_o == 1'b0, "bp_new_accepted", ready_o, 0);
    wait_result(1'b0);
    lit("d_bp_new", 0, 32768, 4, 7071, 3);
    take(0);

    // Reset while iteration 7 is in progress.
    send(20000, 10000);
    repeat (7) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk(valid_o == 1'b0, "mid_rst_valid_o", valid_o, 0);
    chk(ready_o == 1'b1, "mid_rst_ready_o", ready_o, 1);
    chk(mag_o == '0 && angle_o == '0 && quadrant_o == 2'd0, "mid_rst_outputs", mag_o, 0);
    tick();
    directed(3000, 4000, "d_post_rst", 0, 38688, 4, 5000, 3);

    // Random sweep; vectors kept away from the origin where angle resolution vanishes.
    for (int n = 0; n < 300; n++) begin
      do begin
        x = int'($signed(16'($urandom)));
        y = int'($signed(16'($urandom)));
      end while (((x < 0) ? -x : x) + ((y < 0) ? -y : y) < 4096);
      send(x, y);
      wait_result(1'b1);
      take(int'($urandom_range(0, 2)));
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
